// File: rtl/ioshim_pkg.sv
// ioshim_pkg -- shared constants and types for the ioshim_memport block.
//   ADDR_W         : word-address width of both request ports
//   DATA_W         : RAM word width
//   N_LANES        : number of byte-write lanes per word
//   STARVE_MAX_DEF : default bound on host wait cycles while the CPU owns the RAM
//   port_state_e   : per-port request FSM state
package ioshim_pkg;

    localparam int ADDR_W         = 11;
    localparam int DATA_W         = 16;
    localparam int N_LANES        = DATA_W / 8;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic {
        PORT_IDLE = 1'b0,
        PORT_BUSY = 1'b1
    } port_state_e;

endpackage

// File: rtl/ioshim_memport_ram.sv
// ioshim_memport_ram -- synchronous single-port RAM, DATA_W bits wide, with
// one write enable per byte lane and a registered (1-cycle) read.
// Contents are never reset. The read register captures the old word on a
// write cycle (read-first); callers ignore rdata after writes.
//   clk   : clock
//   en    : access strobe (read always, write on enabled lanes)
//   we    : byte-lane write enables
//   addr  : word index
//   wdata : write data
//   rdata : read data, valid the cycle after an enabled access
module ioshim_memport_ram
    import ioshim_pkg::*;
#(
    parameter int MEMSIZE = 128,
    parameter int IDX_W   = $clog2(MEMSIZE)
) (
    input  logic               clk,
    input  logic               en,
    input  logic [N_LANES-1:0] we,
    input  logic [IDX_W-1:0]   addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata
);

    // One byte-wide array per lane keeps each lane a plain inferred RAM.
    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic [7:0] mem_q [MEMSIZE];
            logic [7:0] rdata_q;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we[gi]) begin
                        mem_q[addr] <= wdata[gi*8 +: 8];
                    end
                    rdata_q <= mem_q[addr];
                end
            end

            assign rdata[gi*8 +: 8] = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/ioshim_memport.sv
// ioshim_memport -- shares one single-port RAM between a host (memio) port
// and a CPU port. Each port runs a two-state IDLE/BUSY FSM: a request
// accepted at an edge completes with a one-cycle done pulse in the next
// cycle, with read data valid alongside it and held until the next read
// completion on that port. The CPU wins simultaneous requests unless the
// host has already waited STARVE_MAX cycles.
// Optional feature: define IOSHIM_MEMPORT_STATS_EN to count arbitration
// conflicts in conflict_cnt; otherwise conflict_cnt is tied to zero.
//   clk, resetn                     : clock, asynchronous active-low reset
//   memio_rd/wr/addr/wdata          : host request (wr = byte lanes, wins over rd)
//   memio_rdata, memio_done         : host read data, completion pulse
//   cpu_rd/wr/addr/wdata            : CPU request
//   cpu_rdata, cpu_done             : CPU read data, completion pulse
//   conflict_cnt                    : saturating count of both-port contention edges
module ioshim_memport
    import ioshim_pkg::*;
#(
    parameter int MEMSIZE    = 128,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               memio_rd,
    input  logic [1:0]         memio_wr,
    input  logic [ADDR_W-1:0]  memio_addr,
    input  logic [DATA_W-1:0]  memio_wdata,
    output logic [DATA_W-1:0]  memio_rdata,
    output logic               memio_done,
    input  logic               cpu_rd,
    input  logic [1:0]         cpu_wr,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_done,
    output logic [15:0]        conflict_cnt
);

    localparam int IDX_W  = $clog2(MEMSIZE);
    localparam int WAIT_W = $clog2(STARVE_MAX + 2);
    localparam int HOST   = 0;
    localparam int CPU    = 1;

    // Port-indexed views of the two request interfaces.
    logic [1:0]                 rd_req;
    logic [1:0][N_LANES-1:0]    wr_req;
    logic [1:0][ADDR_W-1:0]     addr_req;
    logic [1:0][DATA_W-1:0]     wdata_req;
    logic [1:0][DATA_W-1:0]     rdata_mux;
    logic [1:0]                 cand;
    logic [1:0]                 grant;
    logic [1:0]                 oob;
    logic [1:0]                 done;

    logic [WAIT_W-1:0]          wait_q, wait_d;
    logic                       host_first;
    logic                       sel;
    logic [N_LANES-1:0]         ram_we;
    logic [DATA_W-1:0]          ram_rdata;

    assign rd_req    = {cpu_rd, memio_rd};
    assign wr_req    = {cpu_wr, memio_wr};
    assign addr_req  = {cpu_addr, memio_addr};
    assign wdata_req = {cpu_wdata, memio_wdata};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            port_state_e       state_q, state_d;
            logic              is_rd_q;
            logic              oob_q;
            logic [DATA_W-1:0] hold_q;
            logic              rd_done;
            logic [DATA_W-1:0] rd_value;

            // Out-of-range accesses still complete; they just never touch the RAM.
            assign oob[gi]   = 32'(addr_req[gi]) >= MEMSIZE;
            // A BUSY port is never a candidate, so a held request is
            // re-accepted only after the done cycle has ended.
            assign cand[gi]  = (rd_req[gi] | (|wr_req[gi])) & (state_q == PORT_IDLE);
            assign state_d   = grant[gi] ? PORT_BUSY : PORT_IDLE;
            assign done[gi]  = (state_q == PORT_BUSY);
            assign rd_done   = (state_q == PORT_BUSY) & is_rd_q;
            assign rd_value  = oob_q ? '0 : ram_rdata;
            // Read data is shown live in the done cycle, then held.
            assign rdata_mux[gi] = rd_done ? rd_value : hold_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    state_q <= PORT_IDLE;
                    is_rd_q <= 1'b0;
                    oob_q   <= 1'b0;
                    hold_q  <= '0;
                end else begin
                    state_q <= state_d;
                    if (grant[gi]) begin
                        is_rd_q <= (wr_req[gi] == '0);
                        oob_q   <= oob[gi];
                    end
                    if (rd_done) begin
                        hold_q <= rd_value;
                    end
                end
            end
        end
    endgenerate

    // One grant per edge: CPU by default, host once it has waited long enough.
    always_comb begin
        grant      = '0;
        host_first = (wait_q == WAIT_W'(STARVE_MAX));
        grant[HOST] = cand[HOST] & (~cand[CPU] | host_first);
        grant[CPU]  = cand[CPU] & ~grant[HOST];
    end

    always_comb begin
        wait_d = wait_q;
        if (grant[HOST]) begin
            wait_d = '0;
        end else if (cand[HOST] && !host_first) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign sel    = grant[CPU];
    assign ram_we = ((|grant) && !oob[sel]) ? wr_req[sel] : '0;

    ioshim_memport_ram #(
        .MEMSIZE (MEMSIZE),
        .IDX_W   (IDX_W)
    ) u_ram (
        .clk   (clk),
        .en    (|grant),
        .we    (ram_we),
        .addr  (addr_req[sel][IDX_W-1:0]),
        .wdata (wdata_req[sel]),
        .rdata (ram_rdata)
    );

    assign memio_rdata = rdata_mux[HOST];
    assign memio_done  = done[HOST];
    assign cpu_rdata   = rdata_mux[CPU];
    assign cpu_done    = done[CPU];

`ifdef IOSHIM_MEMPORT_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            conflict_q <= '0;
        end else if ((&cand) && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule
